axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response stream into AXI4-Lite read and write transactions. It is the master-side counterpart of the team's AXI4-Lite register slaves, such as the I2C controller register file. It lets RTL sequencers (board bring-up, I2C init tables, self-test) drive register blocks without a processor. Exactly one transaction is in flight at a time.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, default 32: data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, default 6: byte address width.
- TIMEOUT_CYCLES, default 255: wait-state cycle limit. Used only with AXIL_MASTER_TIMEOUT_EN.

Ports:
- M_AXI_ACLK, in, 1: the single clock.
- M_AXI_ARESET, in, 1: synchronous, active-high reset.
- cmd_valid / cmd_ready, in / out, 1 each: command handshake.
- cmd_rnw, in, 1: 1 = read, 0 = write.
- cmd_addr, in, ADDR_WIDTH: byte address.
- cmd_wdata, in, DATA_WIDTH: write data.
- cmd_wstrb, in, DATA_WIDTH/8: write byte strobes.
- rsp_valid / rsp_ready, out / in, 1 each: response handshake.
- rsp_rdata, out, DATA_WIDTH: read data; 0 for writes.
- rsp_resp, out, 2: BRESP or RRESP.
- rsp_timeout, out, 1: transaction aborted by timeout.
- busy, out, 1: high whenever the FSM is not in IDLE.
- AXI write address channel: M_AXI_AWADDR, M_AXI_AWPROT (tied 3'b000), M_AXI_AWVALID, M_AXI_AWREADY.
- AXI write data channel: M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WREADY.
- AXI write response channel: M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY.
- AXI read address channel: M_AXI_ARADDR, M_AXI_ARPROT (tied 3'b000), M_AXI_ARVALID, M_AXI_ARREADY.
- AXI read data channel: M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, M_AXI_RREADY.

## Operation
FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.

- **IDLE:** cmd_ready=1. On cmd_valid, register addr/wdata/wstrb/rnw. Go to RD_REQ if rnw=1, otherwise WR_REQ.
- **WR_REQ:**
  - AWVALID and WVALID rise together in the same cycle; the team's slaves require both valid together.
  - Each valid drops independently on its own handshake (VALID&READY), tracked with aw_done and w_done.
  - When both handshakes are done, go to WR_RESP. AW and W handshakes may land in the same cycle or in different cycles.
- **WR_RESP:** BREADY=1. On BVALID, capture BRESP and go to RSP.
- **RD_REQ:** ARVALID=1 until ARREADY, then go to RD_DATA.
- **RD_DATA:** RREADY=1. On RVALID, capture RDATA and RRESP, then go to RSP.
- **RSP:** rsp_valid=1, with rsp_* held stable until rsp_ready, then go to IDLE. cmd_ready stays 0 until IDLE.
- AXI address and data outputs hold their registered values throughout a transaction. VALID never drops before its handshake, except on timeout abort.
- Non-OKAY responses (SLVERR/DECERR) pass through unchanged in rsp_resp. They do not abort.

## Timing
- **Reset values:** all *VALID, BREADY, RREADY, rsp_valid, rsp_timeout and busy = 0; rsp_rdata = 0; rsp_resp = 0; AXI address/data/strobe outputs = 0; cmd_ready = 0 during reset, 1 on the first cycle after. The FSM resets to IDLE.
- **Reset mid-transaction:** all outputs return to reset values at the next edge, and no response is issued.
- **Latency:** AW/W (or AR) valid is asserted the cycle after command accept. rsp_valid is asserted the cycle after the B (or R) handshake. Against a slave that asserts ready one cycle after valid and responds one cycle after the handshake, the write is 4 cycles from cmd accept to rsp_valid, and the read is 4 cycles.
- **Back-to-back:** a new command is accepted no earlier than the cycle after the rsp handshake. Minimum period is 5 cycles.
- **rsp_valid low-to-high:** only in RSP. Held under rsp_ready=0 backpressure indefinitely.

## Configuration
Macro: AXIL_MASTER_TIMEOUT_EN.
- **Defined:**
  - A wait counter clears on entry to each of WR_REQ, WR_RESP, RD_REQ and RD_DATA, and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES without the awaited handshake, all VALID/READY drop at the next edge and the FSM enters RSP.
  - The timeout response is rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
  - A handshake in the same cycle as the terminal count wins: normal completion, no timeout.
- **Undefined:** there is no counter, the FSM waits indefinitely, and rsp_timeout is tied to 0.

## Test plan
- **Write:** cmd write addr=0x0C, wdata=0x0000_0005, wstrb=0xF; slave AWREADY/WREADY after 1 cycle. Required: AWADDR=0x0C, WDATA=5, WSTRB=0xF, AW and W valid asserted together; rsp_resp=0, rsp_rdata=0; rsp_valid 4 cycles after accept.
- **Read:** cmd read addr=0x0C; slave returns RDATA=0x0000_0005, RRESP=0. Required: rsp_rdata=0x5, rsp_resp=0; ARVALID high only until ARREADY.
- **Skewed write handshake:** WREADY 3 cycles before AWREADY. Required: WVALID drops after its handshake, AWVALID holds until its own; exactly one write response.
- **Backpressure and error pass-through:** RRESP=2'b10 with rsp_ready held low 10 cycles. Required: rsp_valid and rsp_resp=2'b10 stable for all 10 cycles; cmd_ready=0 throughout.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):** slave never asserts BVALID. Required: rsp_timeout=1, rsp_resp=2'b10 exactly 16 wait cycles after WR_RESP entry; BREADY low afterward.
- **Mid-read reset:** M_AXI_ARESET pulsed during RD_DATA. Required: all outputs at reset values the next cycle, no rsp_valid, then a following read completes normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator bridging a command/response stream to AXI4-Lite.
// Ports: M_AXI_ACLK clock, M_AXI_ARESET synchronous active-high reset;
//        cmd_* command stream in (rnw/addr/wdata/wstrb); rsp_* response stream out (rdata/resp/timeout);
//        busy high outside IDLE; M_AXI_AW*/W*/B*/AR*/R* AXI4-Lite master channels.
// Optional: define AXIL_MASTER_TIMEOUT_EN to abort any wait state after TIMEOUT_CYCLES cycles.
module axi_lite_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
    state_t state, nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic [1:0]                      resp_q;
    logic                            aw_done, w_done, wr_done, accept, to_hit;
    assign accept  = state == IDLE && cmd_valid;
    // In WR_REQ each valid is the inverse of its done flag, so ready alone marks this cycle's handshake.
    assign wr_done = (aw_done | M_AXI_AWREADY) & (w_done | M_AXI_WREADY);
    always_ff @(posedge M_AXI_ACLK)
        state <= M_AXI_ARESET ? IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (cmd_valid) nxt = cmd_rnw ? RD_REQ : WR_REQ;
            WR_REQ:  if (wr_done) nxt = WR_RESP;
            WR_RESP: if (M_AXI_BVALID) nxt = RSP;
            RD_REQ:  if (M_AXI_ARREADY) nxt = RD_DATA;
            RD_DATA: if (M_AXI_RVALID) nxt = RSP;
            RSP:     if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (to_hit) nxt = RSP;
    end
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                rdata_q <= '0;
                resp_q  <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY) w_done <= 1'b1;
            if (M_AXI_BVALID && M_AXI_BREADY) resp_q <= M_AXI_BRESP;
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                rdata_q <= M_AXI_RDATA;
                resp_q  <= M_AXI_RRESP;
            end
            if (to_hit) begin
                rdata_q <= '0;
                resp_q  <= 2'b10;
            end
        end
    end
    always_comb begin
        cmd_ready     = state == IDLE && !M_AXI_ARESET;
        busy          = state != IDLE;
        rsp_valid     = state == RSP;
        rsp_rdata     = rdata_q;
        rsp_resp      = resp_q;
        M_AXI_AWADDR  = addr_q;
        M_AXI_ARADDR  = addr_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WSTRB   = wstrb_q;
        M_AXI_AWVALID = state == WR_REQ && !aw_done;
        M_AXI_WVALID  = state == WR_REQ && !w_done;
        M_AXI_BREADY  = state == WR_RESP;
        M_AXI_ARVALID = state == RD_REQ;
        M_AXI_RREADY  = state == RD_DATA;
        M_AXI_AWPROT  = 3'b000;
        M_AXI_ARPROT  = 3'b000;
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [31:0] cnt;
    logic        timeout_q, stall;
    // Stalled means still waiting on the awaited handshake; a handshake on the terminal cycle wins.
    assign stall = (state == WR_REQ && !wr_done) || (state == WR_RESP && !M_AXI_BVALID) ||
                   (state == RD_REQ && !M_AXI_ARREADY) || (state == RD_DATA && !M_AXI_RVALID);
    assign to_hit = stall && cnt == 32'(TIMEOUT_CYCLES - 1);
    assign rsp_timeout = timeout_q;
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt       <= nxt != state ? '0 : cnt + 32'd1;
            timeout_q <= accept ? 1'b0 : timeout_q | to_hit;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |(32'(TIMEOUT_CYCLES));
    assign to_hit         = 1'b0;
    assign rsp_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized self-checking bench for axi_lite_master against a word-memory slave model.
module tb_axi_lite_master;
    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0] cmd_wstrb = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [5:0] AWADDR, ARADDR;
    logic [2:0] AWPROT, ARPROT;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0] WSTRB;
    logic [1:0] BRESP, RRESP;
    int n_chk = 0, n_pass = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic never_b = 1'b0;
    logic [5:0] cur_addr = '0;
    logic [31:0] cur_wd = '0;
    logic [3:0] cur_ws = '0;
    logic [31:0] ref_mem [16];
    always #5 clk = ~clk;
    axi_lite_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(6), .TIMEOUT_CYCLES(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );
    // Slave address map: 0x30-0x3F answers SLVERR, 0x28-0x2F DECERR, everything else OKAY.
    function automatic logic [1:0] resp_of(input logic [5:0] a);
        return a[5:4] == 2'b11 ? 2'b10 : (a[5:3] == 3'b101 ? 2'b11 : 2'b00);
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    // ---------------- slave stub: 16-word memory with per-channel ready/response delays
    logic [31:0] mem [16];
    logic aw_got, w_got, ar_got;
    logic [5:0] aw_a, ar_a;
    logic [31:0] w_d;
    logic [3:0] w_s;
    int aw_c, w_c, ar_c, b_c, r_c, b_count;
    wire aw_hs = AWVALID & AWREADY, w_hs = WVALID & WREADY, ar_hs = ARVALID & ARREADY;
    wire aw_now = aw_got | aw_hs, w_now = w_got | w_hs, ar_now = ar_got | ar_hs;
    wire [5:0] aw_a_now = aw_got ? aw_a : AWADDR, ar_a_now = ar_got ? ar_a : ARADDR;
    wire [31:0] w_d_now = w_got ? w_d : WDATA;
    wire [3:0] w_s_now = w_got ? w_s : WSTRB;
    always @(posedge clk) begin
        if (rst) begin
            {AWREADY, WREADY, ARREADY, BVALID, RVALID, aw_got, w_got, ar_got} <= '0;
            {aw_c, w_c, ar_c, b_c, r_c} <= '0;
            BRESP <= '0; RRESP <= '0; RDATA <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (AWVALID && !AWREADY && !aw_got) begin
                if (aw_c >= aw_dly) AWREADY <= 1'b1; else aw_c <= aw_c + 1;
            end else AWREADY <= 1'b0;
            if (WVALID && !WREADY && !w_got) begin
                if (w_c >= w_dly) WREADY <= 1'b1; else w_c <= w_c + 1;
            end else WREADY <= 1'b0;
            if (ARVALID && !ARREADY && !ar_got) begin
                if (ar_c >= ar_dly) ARREADY <= 1'b1; else ar_c <= ar_c + 1;
            end else ARREADY <= 1'b0;
            if (aw_hs) begin aw_got <= 1'b1; aw_a <= AWADDR; aw_c <= 0; end
            if (w_hs) begin w_got <= 1'b1; w_d <= WDATA; w_s <= WSTRB; w_c <= 0; end
            if (ar_hs) begin ar_got <= 1'b1; ar_a <= ARADDR; ar_c <= 0; end
            if (BVALID) begin
                if (BREADY) BVALID <= 1'b0;
            end else if (aw_now && w_now && !never_b) begin
                if (b_c >= b_dly) begin
                    BVALID <= 1'b1;
                    BRESP <= resp_of(aw_a_now);
                    for (int i = 0; i < 4; i++)
                        if (w_s_now[i]) mem[aw_a_now[5:2]][8*i +: 8] <= w_d_now[8*i +: 8];
                    aw_got <= 1'b0; w_got <= 1'b0; b_c <= 0;
                    b_count <= b_count + 1;
                end else b_c <= b_c + 1;
            end
            if (RVALID) begin
                if (RREADY) RVALID <= 1'b0;
            end else if (ar_now) begin
                if (r_c >= r_dly) begin
                    RVALID <= 1'b1;
                    RDATA <= mem[ar_a_now[5:2]];
                    RRESP <= resp_of(ar_a_now);
                    ar_got <= 1'b0; r_c <= 0;
                end else r_c <= r_c + 1;
            end
        end
    end
    // ---------------- protocol monitor: counts rule breaks, checked once at the end
    logic aw_v_q, w_v_q, ar_v_q, aw_hs_q, w_hs_q, ar_hs_q, rst_q;
    int viol_drop = 0, viol_stay = 0, viol_tog = 0, viol_hold = 0, skew_cnt = 0, bready_cnt = 0;
    always @(posedge clk) begin
        {aw_v_q, w_v_q, ar_v_q} <= {AWVALID, WVALID, ARVALID};
        {aw_hs_q, w_hs_q, ar_hs_q} <= {aw_hs, w_hs, ar_hs};
        rst_q <= rst;
    end
    always @(negedge clk) begin
        if (!rst && !rst_q) begin
            viol_drop <= viol_drop + ((aw_v_q && !AWVALID && !aw_hs_q) ? 1 : 0) +
                         ((w_v_q && !WVALID && !w_hs_q) ? 1 : 0) + ((ar_v_q && !ARVALID && !ar_hs_q) ? 1 : 0);
            viol_stay <= viol_stay + ((aw_hs_q && AWVALID) ? 1 : 0) + ((w_hs_q && WVALID) ? 1 : 0) +
                         ((ar_hs_q && ARVALID) ? 1 : 0);
            viol_tog  <= viol_tog + ((!aw_v_q && !w_v_q && AWVALID != WVALID) ? 1 : 0);
            viol_hold <= viol_hold + ((AWVALID && AWADDR != cur_addr) ? 1 : 0) +
                         ((WVALID && (WDATA != cur_wd || WSTRB != cur_ws)) ? 1 : 0) +
                         ((ARVALID && ARADDR != cur_addr) ? 1 : 0) + ((AWPROT != 0 || ARPROT != 0) ? 1 : 0);
            if (AWVALID && !WVALID) skew_cnt <= skew_cnt + 1;
            if (BREADY) bready_cnt <= bready_cnt + 1;
        end
    end
    // ---------------- driver + reference model: one command, expected response from the memory model
    task automatic do_cmd(input logic rnw, input logic [5:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int hold, input int exp_lat, input logic exp_to);
        logic [31:0] e_rd, r0_d;
        logic [1:0] e_rsp, r0_r;
        int n, bad, b0;
        e_rd = rnw ? ref_mem[a[5:2]] : 32'h0;
        e_rsp = resp_of(a);
        if (exp_to) begin
            e_rd = 32'h0;
            e_rsp = 2'b10;
        end else if (!rnw) begin
            for (int i = 0; i < 4; i++) if (ws[i]) ref_mem[a[5:2]][8*i +: 8] = wd[8*i +: 8];
        end
        cur_addr = a; cur_wd = wd; cur_ws = ws; b0 = b_count;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
        check("rsp_valid", rsp_valid, 1);
        if (exp_lat >= 0) check("latency", n, exp_lat);
        r0_d = rsp_rdata; r0_r = rsp_resp; bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== r0_d || rsp_resp !== r0_r || cmd_ready) bad++;
        end
        if (hold > 0) check("rsp_stable", bad, 0);
        check("rdata", rsp_rdata, e_rd);
        check("resp", rsp_resp, e_rsp);
        check("timeout", rsp_timeout, exp_to);
        check("cmd_ready_rsp", cmd_ready, 0);
        if (!rnw && !exp_to) check("b_count", b_count - b0, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask
    initial begin
        logic rnw_r;
        logic [5:0] a_r;
        logic [31:0] d_r;
        logic [3:0] s_r;
        int n, bad, sk0, br0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_timeout, busy, cmd_ready}, 0);
        check("rst_data", {WDATA, rsp_rdata}, 0);
        check("rst_addr", {rsp_resp, AWADDR, ARADDR, WSTRB}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);
        // directed: plain write and read back with one-cycle slave
        do_cmd(1'b0, 6'h0C, 32'h0000_0005, 4'hF, 0, 4, 1'b0);
        do_cmd(1'b1, 6'h0C, 32'h0, 4'h0, 0, 4, 1'b0);
        // directed: W accepted three cycles before AW
        aw_dly = 3; sk0 = skew_cnt;
        do_cmd(1'b0, 6'h14, 32'hA5A5_1234, 4'h5, 0, 7, 1'b0);
        check("skew_cycles", skew_cnt - sk0, 3);
        aw_dly = 0;
        // directed: SLVERR read under ten cycles of response backpressure
        do_cmd(1'b1, 6'h30, 32'h0, 4'h0, 10, 4, 1'b0);
`ifdef AXIL_MASTER_TIMEOUT_EN
        never_b = 1'b1; br0 = bready_cnt;
        do_cmd(1'b0, 6'h10, 32'hDEAD_BEEF, 4'hF, 0, 19, 1'b1);
        check("bready_cycles", bready_cnt - br0, 16);
        check("bready_low", BREADY, 0);
        never_b = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
`endif
        // directed: reset pulse while waiting in RD_DATA
        do_cmd(1'b0, 6'h08, 32'h1357_9BDF, 4'hF, 0, 4, 1'b0);
        r_dly = 6; cur_addr = 6'h08;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 6'h08;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!RREADY && n < 20) begin @(negedge clk); n++; end
        check("in_rd_data", RREADY, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctl", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_timeout, busy, cmd_ready}, 0);
        check("midrst_data", {rsp_resp, rsp_rdata, AWADDR, WSTRB}, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || !cmd_ready) bad++;
        end
        check("midrst_quiet", bad, 0);
        r_dly = 0;
        do_cmd(1'b0, 6'h08, 32'h2468_ACE0, 4'hF, 0, 4, 1'b0);
        do_cmd(1'b1, 6'h08, 32'h0, 4'h0, 0, 4, 1'b0);
        // randomized traffic with random slave timing and response backpressure
        for (int t = 0; t < 60; t++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 2);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 2);
            rnw_r = 1'($urandom_range(0, 1));
            a_r = {4'($urandom), 2'b00};
            d_r = $urandom;
            s_r = 4'($urandom);
            do_cmd(rnw_r, a_r, d_r, s_r, $urandom_range(0, 3),
                   rnw_r ? 4 + ar_dly + r_dly : 4 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly, 1'b0);
        end
        @(negedge clk);
        check("viol_drop", viol_drop, 0);
        check("viol_stay", viol_stay, 0);
        check("viol_together", viol_tog, 0);
        check("viol_hold", viol_hold, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
